// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and default sizing for the round-robin arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int ARB_NUM_REQ  = 4;
  localparam int ARB_MAX_LOCK = 4;
endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: index of the lowest set bit plus an any-set flag
module priority_encoder #(
  parameter int WIDTH = 4,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out_LSB,
  output logic             valid
);
  always_comb begin
    out_LSB = '0;
    valid = |in;
    for (int i = WIDTH - 1; i >= 0; i--) if (in[i]) out_LSB = OUT_W'(i);
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant and bounded lock bursts
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int MAX_LOCK = ARB_MAX_LOCK,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);
  localparam int LCW = $clog2(MAX_LOCK + 1);
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, nxt_ptr, arb_ptr, m_idx, r_idx, win;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, masked;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic m_valid, r_valid, xfer, withdraw, keep_lock, release_g, rearb;
  assign xfer      = (state_q == GRANT) & ready & req[gnt_idx_q];
  assign withdraw  = (state_q == GRANT) & ~req[gnt_idx_q];
  assign keep_lock = xfer & lock[gnt_idx_q] & (lock_cnt_q < LCW'(MAX_LOCK - 1));
  assign release_g = xfer & ~keep_lock;
  assign rearb     = (state_q == IDLE) | withdraw | release_g;
  assign nxt_ptr   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
  // A release searches from the rotated pointer in the same cycle, so no bubble
  assign arb_ptr   = release_g ? nxt_ptr : ptr_q;
  assign masked    = req & ~((NUM_REQ'(1) << arb_ptr) - NUM_REQ'(1));
  assign win       = m_valid ? m_idx : r_idx;
  priority_encoder #(.WIDTH(NUM_REQ), .OUT_W(IDX_W)) u_pe_masked (
    .in(masked), .out_LSB(m_idx), .valid(m_valid)
  );
  priority_encoder #(.WIDTH(NUM_REQ), .OUT_W(IDX_W)) u_pe_req (
    .in(req), .out_LSB(r_idx), .valid(r_valid)
  );
  always_comb begin
    state_d    = state_q;
    ptr_d      = release_g ? nxt_ptr : ptr_q;
    lock_cnt_d = release_g ? '0 : keep_lock ? lock_cnt_q + 1'b1 : lock_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    if (rearb) begin
      state_d   = r_valid ? GRANT : IDLE;
      gnt_idx_d = r_valid ? win : '0;
    end
    gnt_d = (state_d == GRANT) ? NUM_REQ'(1) << gnt_idx_d : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_q      <= gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == GRANT);
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed vectors with hand-computed expectations for rr_arbiter
module tb_rr_arbiter;
  logic       clk = 0, rst = 1, ready = 0, gnt_valid;
  logic [3:0] req = 0, lock = 0, gnt;
  logic [1:0] gnt_idx;
  int n_chk = 0, n_fail = 0;
  int seq_idx [6] = '{0, 1, 2, 3, 0, 1};
  rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .ready(ready),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_valid", gnt_valid, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    rst = 0;
    req = 4'b1010;
    tick();
    chk("basic_gnt", gnt, 4'b0010);
    chk("basic_idx", gnt_idx, 1);
    chk("basic_valid", gnt_valid, 1);
    ready = 1;
    tick();
    chk("basic_gnt2", gnt, 4'b1000);
    chk("basic_idx2", gnt_idx, 3);
    chk("basic_ptr2", dut.ptr_q, 2);
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fair_%0d", i), gnt_idx, seq_idx[i]);
      chk($sformatf("fair_valid_%0d", i), gnt_valid, 1);
    end
    lock = 4'b0100;
    tick();
    chk("lock_start_idx", gnt_idx, 2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("lock_hold_idx_%0d", i), gnt_idx, 2);
      chk($sformatf("lock_cnt_%0d", i), dut.lock_cnt_q, i);
    end
    tick();
    chk("lock_release_idx", gnt_idx, 3);
    chk("lock_release_cnt", dut.lock_cnt_q, 0);
    lock = 0;
    ready = 0;
    req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req = 4'b1001;
      tick();
      chk($sformatf("stall_gnt_%0d", i), gnt, 4'b1000);
    end
    ready = 1;
    tick();
    chk("stall_after_idx", gnt_idx, 0);
    req = 4'b0011;
    tick();
    chk("wd_pre_idx", gnt_idx, 1);
    chk("wd_pre_ptr", dut.ptr_q, 1);
    ready = 0;
    req = 4'b0100;
    tick();
    chk("wd_idx", gnt_idx, 2);
    chk("wd_ptr", dut.ptr_q, 1);
    chk("wd_cnt", dut.lock_cnt_q, 0);
    req = 4'b1111;
    lock = 4'b0100;
    ready = 1;
    tick();
    tick();
    chk("rstlock_idx", gnt_idx, 2);
    chk("rstlock_cnt", dut.lock_cnt_q, 2);
    rst = 1;
    tick();
    chk("rstlock_gnt", gnt, 0);
    chk("rstlock_gidx", gnt_idx, 0);
    chk("rstlock_valid", gnt_valid, 0);
    chk("rstlock_ptr", dut.ptr_q, 0);
    chk("rstlock_cnt0", dut.lock_cnt_q, 0);
    rst = 0;
    lock = 0;
    ready = 0;
    tick();
    chk("post_rst_gnt", gnt, 4'b0001);
    req = 0;
    ready = 1;
    tick();
    chk("idle_valid", gnt_valid, 0);
    chk("idle_gnt", gnt, 0);
    req = 4'b0001;
    tick();
    chk("solo_gnt", gnt, 4'b0001);
    tick();
    chk("solo_again_gnt", gnt, 4'b0001);
    chk("solo_ptr", dut.ptr_q, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
